countdown_timer_bcd: RTL and testbench
======================================

Name: countdown_timer_bcd

Overview:
Parametrised mm:ss BCD countdown timer for the microwave controller. It is the successor to the fixed three-counter timer.
- Minute digit count is configurable.
- Built-in 1 Hz tick prescaler.
- Explicit run/pause/done state machine.
- Load validation.
- Single-cycle completion pulse.

It sits between the keypad/BCD entry logic and the display driver and magnetron-control FSM.

Parameters:
MIN_DIGITS, 2, number of cascaded BCD minute digits (1..3).
TICKS_PER_SEC, 50000000, clk cycles per one-second decrement (>=2).
TICK_W, 26, prescaler counter width; must satisfy 2**TICK_W >= TICKS_PER_SEC.

Ports:
clk  in  1  system clock, all logic on rising edge
clear  in  1  asynchronous active-high reset
load  in  1  load min_in/sec_tens_in/sec_ones_in (level sampled each edge)
start  in  1  start or resume countdown
pause  in  1  pause a running countdown
cancel  in  1  abort; zero the time, return to IDLE
min_in  in  4*MIN_DIGITS  BCD minutes, MS digit in top nibble
sec_tens_in  in  4  BCD seconds tens (0..5)
sec_ones_in  in  4  BCD seconds ones (0..9)
min_out  out  4*MIN_DIGITS  current BCD minutes
sec_tens_out  out  4  current seconds tens
sec_ones_out  out  4  current seconds ones
running  out  1  high in RUNNING
paused  out  1  high in PAUSED
done  out  1  one-cycle pulse on reaching 00:00
load_err  out  1  one-cycle pulse on rejected load
zero  out  1  combinational: all digits == 0

Behaviour:
- Reset (clear=1, async): all digits 0, prescaler 0, state IDLE, done=0, load_err=0; running and paused therefore 0.
- States:
  - IDLE: time may be zero or loaded.
  - RUNNING.
  - PAUSED.
  - DONE.
- Command priority each edge: cancel > load > start > pause.
  - Lower-priority commands are ignored that cycle.
- cancel: from any state, digits <= 0, prescaler <= 0, state <= IDLE.
- load:
  - Accepted only in IDLE, PAUSED and DONE; ignored without error in RUNNING.
  - A load is valid only if every minute digit <= 9, sec_tens_in <= 5 and sec_ones_in <= 9.
  - Valid load: digits <= inputs, prescaler <= 0, state <= IDLE.
  - Invalid load: digits unchanged, load_err=1 for the next cycle.
- start:
  - From IDLE or PAUSED with zero=0: state <= RUNNING.
  - From IDLE, prescaler <= 0. From PAUSED, the prescaler value is retained.
  - start with zero=1, or in DONE, is ignored.
- pause: in RUNNING, state <= PAUSED, prescaler and digits frozen. In other states it is ignored.
- Tick:
  - In RUNNING the prescaler increments each cycle.
  - When prescaler == TICKS_PER_SEC-1, the prescaler wraps to 0 and the time decrements by one second on the same edge.
  - First decrement occurs TICKS_PER_SEC cycles after the edge that accepted start from IDLE.
- Decrement chain:
  - ones 0 -> 9 with borrow, else ones-1.
  - tens (on borrow) 0 -> 5 with borrow, else tens-1.
  - Each minute digit (on borrow) 0 -> 9 with borrow to the next digit, else digit-1.
  - 00:00 is never decremented; no wrap to all-nines.
- Completion:
  - The edge that writes 00:00 also sets state <= DONE and registers done=1.
  - done is high exactly one cycle, coinciding with outputs showing 00:00.
  - DONE holds until cancel or a valid load.
- pause on the same edge as the final tick: pause wins, because commands are evaluated before the tick. The state goes to PAUSED, the digits are not decremented and the prescaler freezes.
- Maximum value (e.g. 99:59 for MIN_DIGITS=2) counts down normally.
- Outputs are all registered except zero.

Decomposition:
- Package countdown_timer_pkg:
  - state encoding (IDLE=2'd0, RUNNING=2'd1, PAUSED=2'd2, DONE=2'd3).
  - BCD digit width constant (4).
  - Seconds-tens max (5).
  - Digit max (9).
- Sub-module bcd_down_digit, parameter MAXV:
  - inputs: clk, clear, ld, ld_val, dec.
  - outputs: q, borrow_out, where borrow_out = dec && q==0.
  - Instantiated MIN_DIGITS+2 times: MAXV=9 for ones and minutes, MAXV=5 for tens.
- The FSM and prescaler live in the top module.

Test Plan:
All scenarios use TICKS_PER_SEC=4 and MIN_DIGITS=2.
- Reset and load: assert clear mid-count -> all outputs 0 immediately, without waiting for clk; then load 01:05 -> outputs 01:05, state IDLE, running=0.
- Countdown: load 00:02, start -> 00:01 after 4 cycles, 00:00 after 8 cycles; done high exactly one cycle on the 00:00 edge; running=0 afterwards.
- Borrow chain: load 10:00, start, one tick -> 09:59. Load 01:00, one tick -> 00:59.
- Pause/resume: start 00:05, pause 2 cycles after start, hold 10 cycles -> digits 00:05, prescaler frozen; start -> first decrement 2 cycles later.
- Invalid load: load sec_tens_in=6 -> load_err pulse, digits unchanged. Load while RUNNING -> ignored, no load_err. start with 00:00 -> stays IDLE, done never asserted.
- Priority: cancel+load+start on one edge -> 00:00, IDLE. Load+start on one edge -> loaded, IDLE (start ignored).

Source files
------------

// File: rtl/countdown_timer_bcd_pkg.sv
// Shared encodings and BCD limits for the mm:ss countdown timer.
package countdown_timer_pkg;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] DIGIT_MAX    = 4'd9;
   localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_PAUSED  = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

endpackage

// File: rtl/countdown_timer_bcd_digit.sv
// One loadable BCD down-counting digit; wraps 0 -> MAXV and reports a borrow.
module bcd_down_digit
   import countdown_timer_pkg::*;
#(
   parameter logic [DIGIT_W-1:0] MAXV = DIGIT_MAX
) (
   input  logic               clk,
   input  logic               clear,
   input  logic               ld,
   input  logic [DIGIT_W-1:0] ld_val,
   input  logic               dec,
   output logic [DIGIT_W-1:0] q,
   output logic               borrow_out
);

   logic [DIGIT_W-1:0] q_q, q_d;

   always_comb begin
      // NOTE: q_d gets a default before any branch so no path can infer a latch.
      q_d = q_q;
      if (ld) begin
         q_d = ld_val;
      end else if (dec) begin
         q_d = (q_q == '0) ? MAXV : q_q - 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignment only.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) q_q <= '0;
      else       q_q <= q_d;
   end

   assign q          = q_q;
   assign borrow_out = dec && (q_q == '0);

endmodule

// File: rtl/countdown_timer_bcd.sv
// mm:ss BCD countdown timer: command decode, 1 Hz prescaler and run/pause/done FSM.
module countdown_timer_bcd
   import countdown_timer_pkg::*;
#(
   parameter int MIN_DIGITS    = 2,
   parameter int TICKS_PER_SEC = 50000000,
   parameter int TICK_W        = 26
) (
   input  logic                          clk,
   input  logic                          clear,
   input  logic                          load,
   input  logic                          start,
   input  logic                          pause,
   input  logic                          cancel,
   input  logic [DIGIT_W*MIN_DIGITS-1:0] min_in,
   input  logic [DIGIT_W-1:0]            sec_tens_in,
   input  logic [DIGIT_W-1:0]            sec_ones_in,
   output logic [DIGIT_W*MIN_DIGITS-1:0] min_out,
   output logic [DIGIT_W-1:0]            sec_tens_out,
   output logic [DIGIT_W-1:0]            sec_ones_out,
   output logic                          running,
   output logic                          paused,
   output logic                          done,
   output logic                          load_err,
   output logic                          zero
);

   localparam int MW = DIGIT_W * MIN_DIGITS;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);

   state_e              state_q, state_d;
   logic [TICK_W-1:0]   presc_q, presc_d;
   logic                running_q, paused_q, done_q, done_d, load_err_q, load_err_d;
   logic                dig_ld, dig_clr, tick, dec, load_ok, one_left;
   logic [MW-1:0]       min_q, min_ld_val;
   logic [DIGIT_W-1:0]  tens_q, ones_q, tens_ld_val, ones_ld_val;
   logic                ones_borrow, tens_borrow;
   logic [MIN_DIGITS:0] min_chain;
   logic                msd_borrow_unused;

   always_comb begin
      load_ok = (sec_tens_in <= SEC_TENS_MAX) && (sec_ones_in <= DIGIT_MAX);
      for (int i = 0; i < MIN_DIGITS; i++) begin
         if (min_in[DIGIT_W*i +: DIGIT_W] > DIGIT_MAX) load_ok = 1'b0;
      end
   end

   assign zero     = (min_q == '0) && (tens_q == '0) && (ones_q == '0);
   assign one_left = (min_q == '0) && (tens_q == '0) && (ones_q == DIGIT_W'(1));

   // Commands are resolved first; the tick only runs when the winning command left RUNNING untouched.
   always_comb begin
      state_d    = state_q;
      presc_d    = presc_q;
      dig_ld     = 1'b0;
      dig_clr    = 1'b0;
      tick       = 1'b0;
      dec        = 1'b0;
      done_d     = 1'b0;
      load_err_d = 1'b0;
      if (cancel) begin
         dig_ld  = 1'b1;
         dig_clr = 1'b1;
         presc_d = '0;
         state_d = ST_IDLE;
      end else if (load) begin
         if (state_q == ST_RUNNING) begin
            tick = 1'b1;
         end else if (load_ok) begin
            dig_ld  = 1'b1;
            presc_d = '0;
            state_d = ST_IDLE;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (start) begin
         if ((state_q == ST_IDLE || state_q == ST_PAUSED) && !zero) begin
            if (state_q == ST_IDLE) presc_d = '0;
            state_d = ST_RUNNING;
         end else begin
            tick = (state_q == ST_RUNNING);
         end
      end else if (pause) begin
         if (state_q == ST_RUNNING) state_d = ST_PAUSED;
      end else begin
         tick = (state_q == ST_RUNNING);
      end

      if (tick) begin
         if (presc_q == TICK_LAST) begin
            presc_d = '0;
            dec     = !zero;
            if (one_left) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_q    <= ST_IDLE;
         presc_q    <= '0;
         running_q  <= 1'b0;
         paused_q   <= 1'b0;
         done_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         running_q  <= (state_d == ST_RUNNING);
         paused_q   <= (state_d == ST_PAUSED);
         done_q     <= done_d;
         load_err_q <= load_err_d;
      end
   end

   assign min_ld_val  = dig_clr ? '0 : min_in;
   assign tens_ld_val = dig_clr ? '0 : sec_tens_in;
   assign ones_ld_val = dig_clr ? '0 : sec_ones_in;

   bcd_down_digit #(.MAXV(DIGIT_MAX)) u_ones (
      .clk(clk), .clear(clear), .ld(dig_ld), .ld_val(ones_ld_val),
      .dec(dec), .q(ones_q), .borrow_out(ones_borrow)
   );

   bcd_down_digit #(.MAXV(SEC_TENS_MAX)) u_tens (
      .clk(clk), .clear(clear), .ld(dig_ld), .ld_val(tens_ld_val),
      .dec(ones_borrow), .q(tens_q), .borrow_out(tens_borrow)
   );

   assign min_chain[0] = tens_borrow;

   for (genvar i = 0; i < MIN_DIGITS; i++) begin : g_min
      bcd_down_digit #(.MAXV(DIGIT_MAX)) u_digit (
         .clk(clk), .clear(clear), .ld(dig_ld),
         .ld_val(min_ld_val[DIGIT_W*i +: DIGIT_W]),
         .dec(min_chain[i]), .q(min_q[DIGIT_W*i +: DIGIT_W]),
         .borrow_out(min_chain[i+1])
      );
   end

   // 00:00 is never decremented, so the top minute borrow cannot fire.
   assign msd_borrow_unused = min_chain[MIN_DIGITS];

   assign min_out      = min_q;
   assign sec_tens_out = tens_q;
   assign sec_ones_out = ones_q;
   assign running      = running_q;
   assign paused       = paused_q;
   assign done         = done_q;
   assign load_err     = load_err_q;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Self-checking bench: seconds-based reference model, vector table, directed corners, random run.
module tb_countdown_timer_bcd;

   logic       clk = 1'b0;
   logic       clear = 1'b1;
   logic       load = 1'b0, start = 1'b0, pause = 1'b0, cancel = 1'b0;
   logic [7:0] min_in = '0;
   logic [3:0] sec_tens_in = '0, sec_ones_in = '0;
   logic [7:0] min_out;
   logic [3:0] sec_tens_out, sec_ones_out;
   logic       running, paused, done, load_err, zero;

   int checks = 0;
   int errors = 0;

   countdown_timer_bcd #(.MIN_DIGITS(2), .TICKS_PER_SEC(4), .TICK_W(3)) dut (
      .clk(clk), .clear(clear), .load(load), .start(start), .pause(pause), .cancel(cancel),
      .min_in(min_in), .sec_tens_in(sec_tens_in), .sec_ones_in(sec_ones_in),
      .min_out(min_out), .sec_tens_out(sec_tens_out), .sec_ones_out(sec_ones_out),
      .running(running), .paused(paused), .done(done), .load_err(load_err), .zero(zero)
   );

   always #5 clk = ~clk;

   // Reference model: remaining time in whole seconds plus a cycle count within the second.
   localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;
   int m_t, m_p, m_st;
   bit m_done, m_err;

   task automatic model_reset();
      m_t = 0; m_p = 0; m_st = S_IDLE; m_done = 0; m_err = 0;
   endtask

   function automatic bit model_valid(logic [7:0] mi, logic [3:0] ti, logic [3:0] oi);
      return (mi[7:4] <= 9) && (mi[3:0] <= 9) && (ti <= 5) && (oi <= 9);
   endfunction

   task automatic model_tick();
      if (m_p == 3) begin
         m_p = 0;
         if (m_t > 0) begin
            m_t = m_t - 1;
            if (m_t == 0) begin m_st = S_DONE; m_done = 1; end
         end
      end else begin
         m_p = m_p + 1;
      end
   endtask

   task automatic model_step();
      m_done = 0; m_err = 0;
      if (cancel) begin
         m_t = 0; m_p = 0; m_st = S_IDLE;
      end else if (load) begin
         if (m_st == S_RUN) model_tick();
         else if (model_valid(min_in, sec_tens_in, sec_ones_in)) begin
            m_t = (int'(min_in[7:4]) * 10 + int'(min_in[3:0])) * 60
                  + int'(sec_tens_in) * 10 + int'(sec_ones_in);
            m_p = 0; m_st = S_IDLE;
         end else m_err = 1;
      end else if (start) begin
         if ((m_st == S_IDLE || m_st == S_PAUSE) && m_t != 0) begin
            if (m_st == S_IDLE) m_p = 0;
            m_st = S_RUN;
         end else if (m_st == S_RUN) model_tick();
      end else if (pause) begin
         if (m_st == S_RUN) m_st = S_PAUSE;
      end else if (m_st == S_RUN) begin
         model_tick();
      end
   endtask

   function automatic logic [20:0] model_obs();
      int mins = m_t / 60;
      int secs = m_t % 60;
      return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10),
              m_st == S_RUN, m_st == S_PAUSE, m_done, m_err, m_t == 0};
   endfunction

   function automatic logic [20:0] dut_obs();
      return {min_out, sec_tens_out, sec_ones_out, running, paused, done, load_err, zero};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input bit ld, input bit st, input bit pa, input bit ca,
                       input logic [7:0] mi, input logic [3:0] ti, input logic [3:0] oi);
      load = ld; start = st; pause = pa; cancel = ca;
      min_in = mi; sec_tens_in = ti; sec_ones_in = oi;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("model", dut_obs(), model_obs());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00, 4'd0, 4'd0);
   endtask

   task automatic expect_time(input string name, input logic [7:0] mm,
                              input logic [3:0] t, input logic [3:0] o);
      check(name, {min_out, sec_tens_out, sec_ones_out}, {mm, t, o});
   endtask

   typedef struct {
      bit ld, st, pa, ca;
      logic [7:0] mi;
      logic [3:0] ti, oi;
      logic [7:0] e_min;
      logic [3:0] e_t, e_o;
      bit e_run, e_done, e_err;
   } vec_t;

   vec_t vecs[18];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{1'b0,1'b0,1'b0,1'b1, 8'h00,4'd0,4'd0, 8'h00,4'd0,4'd0, 1'b0,1'b0,1'b0};
      vecs[1]  = '{1'b1,1'b0,1'b0,1'b0, 8'h12,4'd3,4'd4, 8'h12,4'd3,4'd4, 1'b0,1'b0,1'b0};
      vecs[2]  = '{1'b1,1'b0,1'b0,1'b0, 8'h00,4'd6,4'd0, 8'h12,4'd3,4'd4, 1'b0,1'b0,1'b1};
      vecs[3]  = '{1'b1,1'b0,1'b0,1'b0, 8'h1A,4'd0,4'd0, 8'h12,4'd3,4'd4, 1'b0,1'b0,1'b1};
      vecs[4]  = '{1'b1,1'b0,1'b0,1'b0, 8'h00,4'd0,4'hA, 8'h12,4'd3,4'd4, 1'b0,1'b0,1'b1};
      vecs[5]  = '{1'b1,1'b1,1'b0,1'b1, 8'h05,4'd0,4'd0, 8'h00,4'd0,4'd0, 1'b0,1'b0,1'b0};
      vecs[6]  = '{1'b1,1'b1,1'b0,1'b0, 8'h00,4'd0,4'd3, 8'h00,4'd0,4'd3, 1'b0,1'b0,1'b0};
      vecs[7]  = '{1'b0,1'b1,1'b0,1'b0, 8'h00,4'd0,4'd0, 8'h00,4'd0,4'd3, 1'b1,1'b0,1'b0};
      vecs[8]  = '{1'b1,1'b0,1'b0,1'b0, 8'h07,4'd0,4'd7, 8'h00,4'd0,4'd3, 1'b1,1'b0,1'b0};
      vecs[9]  = '{1'b0,1'b0,1'b1,1'b0, 8'h00,4'd0,4'd0, 8'h00,4'd0,4'd3, 1'b0,1'b0,1'b0};
      vecs[10] = '{1'b0,1'b0,1'b0,1'b1, 8'h00,4'd0,4'd0, 8'h00,4'd0,4'd0, 1'b0,1'b0,1'b0};
      vecs[11] = '{1'b0,1'b1,1'b0,1'b0, 8'h00,4'd0,4'd0, 8'h00,4'd0,4'd0, 1'b0,1'b0,1'b0};
      vecs[12] = '{1'b1,1'b0,1'b0,1'b0, 8'h99,4'd5,4'd9, 8'h99,4'd5,4'd9, 1'b0,1'b0,1'b0};
      vecs[13] = '{1'b0,1'b1,1'b0,1'b0, 8'h00,4'd0,4'd0, 8'h99,4'd5,4'd9, 1'b1,1'b0,1'b0};
      vecs[14] = '{1'b0,1'b0,1'b0,1'b0, 8'h00,4'd0,4'd0, 8'h99,4'd5,4'd9, 1'b1,1'b0,1'b0};
      vecs[15] = '{1'b0,1'b0,1'b0,1'b0, 8'h00,4'd0,4'd0, 8'h99,4'd5,4'd9, 1'b1,1'b0,1'b0};
      vecs[16] = '{1'b0,1'b0,1'b0,1'b0, 8'h00,4'd0,4'd0, 8'h99,4'd5,4'd9, 1'b1,1'b0,1'b0};
      vecs[17] = '{1'b0,1'b0,1'b0,1'b0, 8'h00,4'd0,4'd0, 8'h99,4'd5,4'd8, 1'b1,1'b0,1'b0};

      // Reset state.
      model_reset();
      repeat (2) @(negedge clk);
      check("reset", dut_obs(), 21'h1);
      clear = 1'b0;

      // Async clear mid-count, then a plain load.
      step(1, 0, 0, 0, 8'h00, 4'd0, 4'd9);
      step(0, 1, 0, 0, 8'h00, 4'd0, 4'd0);
      idle(5);
      expect_time("pre_clear", 8'h00, 4'd0, 4'd8);
      #2 clear = 1'b1;
      #1 check("async_clear", dut_obs(), 21'h1);
      model_reset();
      #1 clear = 1'b0;
      step(1, 0, 0, 0, 8'h01, 4'd0, 4'd5);
      expect_time("load_0105", 8'h01, 4'd0, 4'd5);
      check("load_idle_running", running, 1'b0);

      // Countdown to completion.
      step(1, 0, 0, 0, 8'h00, 4'd0, 4'd2);
      step(0, 1, 0, 0, 8'h00, 4'd0, 4'd0);
      for (int k = 1; k <= 8; k++) begin
         idle(1);
         if (k == 4) expect_time("cd_first_tick", 8'h00, 4'd0, 4'd1);
         if (k == 7) check("cd_done_early", done, 1'b0);
         if (k == 8) begin
            expect_time("cd_zero", 8'h00, 4'd0, 4'd0);
            check("cd_done_pulse", done, 1'b1);
         end
      end
      idle(1);
      check("cd_done_drop", {done, running}, 2'b00);

      // Borrow chain.
      step(1, 0, 0, 0, 8'h10, 4'd0, 4'd0);
      step(0, 1, 0, 0, 8'h00, 4'd0, 4'd0);
      idle(4);
      expect_time("borrow_1000", 8'h09, 4'd5, 4'd9);
      step(0, 0, 0, 1, 8'h00, 4'd0, 4'd0);
      step(1, 0, 0, 0, 8'h01, 4'd0, 4'd0);
      step(0, 1, 0, 0, 8'h00, 4'd0, 4'd0);
      idle(4);
      expect_time("borrow_0100", 8'h00, 4'd5, 4'd9);

      // Pause/resume keeps the partial second.
      step(0, 0, 0, 1, 8'h00, 4'd0, 4'd0);
      step(1, 0, 0, 0, 8'h00, 4'd0, 4'd5);
      step(0, 1, 0, 0, 8'h00, 4'd0, 4'd0);
      idle(2);
      step(0, 0, 1, 0, 8'h00, 4'd0, 4'd0);
      idle(10);
      expect_time("pause_hold", 8'h00, 4'd0, 4'd5);
      check("pause_flag", {paused, running}, 2'b10);
      step(0, 1, 0, 0, 8'h00, 4'd0, 4'd0);
      idle(1);
      expect_time("resume_plus1", 8'h00, 4'd0, 4'd5);
      idle(1);
      expect_time("resume_plus2", 8'h00, 4'd0, 4'd4);

      // Invalid load, load while running, start at zero.
      step(0, 0, 0, 1, 8'h00, 4'd0, 4'd0);
      step(1, 0, 0, 0, 8'h01, 4'd0, 4'd5);
      step(1, 0, 0, 0, 8'h02, 4'd6, 4'd0);
      check("bad_load_err", load_err, 1'b1);
      expect_time("bad_load_keep", 8'h01, 4'd0, 4'd5);
      idle(1);
      check("bad_load_err_drop", load_err, 1'b0);
      step(0, 1, 0, 0, 8'h00, 4'd0, 4'd0);
      step(1, 0, 0, 0, 8'h03, 4'd0, 4'd0);
      expect_time("run_load_ignored", 8'h01, 4'd0, 4'd5);
      check("run_load_no_err", load_err, 1'b0);
      step(0, 0, 0, 1, 8'h00, 4'd0, 4'd0);
      step(0, 1, 0, 0, 8'h00, 4'd0, 4'd0);
      check("zero_start_idle", running, 1'b0);
      idle(6);
      check("zero_start_no_done", {done, running}, 2'b00);

      // Vector table.
      for (int i = 0; i < 18; i++) begin
         step(vecs[i].ld, vecs[i].st, vecs[i].pa, vecs[i].ca, vecs[i].mi, vecs[i].ti, vecs[i].oi);
         check($sformatf("vec%0d", i),
               {min_out, sec_tens_out, sec_ones_out, running, done, load_err},
               {vecs[i].e_min, vecs[i].e_t, vecs[i].e_o, vecs[i].e_run, vecs[i].e_done, vecs[i].e_err});
      end

      // Random commands against the model.
      for (int n = 0; n < 3000; n++) begin
         bit ca, ld, st, pa;
         logic [7:0] mi;
         logic [3:0] ti, oi;
         int sel;
         ca = ($urandom_range(0, 99) < 2);
         ld = ($urandom_range(0, 99) < 8);
         st = ($urandom_range(0, 99) < 14);
         pa = ($urandom_range(0, 99) < 5);
         sel = $urandom_range(0, 99);
         if (sel < 60) begin
            mi = 8'h00; ti = 4'd0; oi = 4'($urandom_range(0, 9));
         end else if (sel < 85) begin
            mi = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            ti = 4'($urandom_range(0, 5)); oi = 4'($urandom_range(0, 9));
         end else begin
            mi = 8'($urandom_range(0, 255));
            ti = 4'($urandom_range(0, 15)); oi = 4'($urandom_range(0, 15));
         end
         step(ld, st, pa, ca, mi, ti, oi);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
